systolic_seq_ctrl: RTL and testbench

//  Sequencer for the NxN weight-stationary Systolic_Array. Preloads N weight rows via the north edge (Wen),

---
 rtl/systolic_pkg.sv | 18 +
 rtl/systolic_seq_ctrl_skew_line.sv | 34 +++
 rtl/systolic_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared sizing, latency and FSM encoding for the systolic array sequencer.
package systolic_pkg;

   localparam int N       = 4;
   localparam int DW      = 8;
   localparam int ARR_LAT = 8;
   // A tag set on accept must line up with the deskewed result of that vector.
   localparam int TAG_LEN = ARR_LAT + N - 1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_WLOAD  = 3'd1;
   localparam state_t ST_STREAM = 3'd2;
   localparam state_t ST_FLUSH  = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// Fixed-depth shift register with a hold enable; used for the west-edge skew and result deskew.
module skew_line #(
   parameter int DEPTH = 1,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = ^{clk, rst, en};
         assign q = d;
      end else begin : g_pipe
         logic [DW-1:0] pipe_q [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
            end else if (en) begin
               pipe_q[0] <= d;
               for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign q = pipe_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the NxN weight-stationary array: weight preload, skewed activation
// streaming, result deskew with a matching valid tag, and a completion pulse.
module systolic_seq_ctrl
   import systolic_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [7:0]      num_vec,
   input  logic            pause_req,
   output logic            busy,
   output logic            done,
   input  logic            w_valid,
   output logic            w_ready,
   input  logic [N*DW-1:0] w_data,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [N*DW-1:0] a_data,
   output logic            arr_wen,
   output logic            arr_pause,
   output logic [N*DW-1:0] arr_north,
   output logic [N*DW-1:0] arr_west,
   input  logic [N*DW-1:0] arr_res,
   output logic            res_valid,
   output logic [N*DW-1:0] res_data
);

   localparam int CW = $clog2(N + 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic [7:0]      vcnt_q, vcnt_d;
   logic [7:0]      num_vec_q, num_vec_d;
   logic [7:0]      inflight_q, inflight_d;
   logic            arr_wen_q, arr_pause_q;
   logic [N*DW-1:0] arr_north_q;
   logic [TAG_LEN-1:0] tag_q;
   logic [N*DW-1:0] res_deskew;
   logic            run, w_acc, a_acc;

   assign run     = ~pause_req;
   assign w_ready = (state_q == ST_WLOAD) && run;
   assign a_ready = (state_q == ST_STREAM) && run;
   assign w_acc   = w_valid & w_ready;
   assign a_acc   = a_valid & a_ready;

   assign busy      = (state_q == ST_WLOAD) || (state_q == ST_STREAM) || (state_q == ST_FLUSH);
   assign done      = (state_q == ST_DONE);
   assign res_valid = tag_q[TAG_LEN-1];
   assign res_data  = res_valid ? res_deskew : '0;
   assign arr_wen   = arr_wen_q;
   assign arr_pause = arr_pause_q;
   assign arr_north = arr_north_q;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      vcnt_d     = vcnt_q;
      num_vec_d  = num_vec_q;
      inflight_d = inflight_q;
      if (run) begin
         if (a_acc && !res_valid && inflight_q != 8'hFF)
            inflight_d = inflight_q + 8'd1;
         else if (!a_acc && res_valid && inflight_q != 8'd0)
            inflight_d = inflight_q - 8'd1;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  num_vec_d = num_vec;
                  wcnt_d    = '0;
                  vcnt_d    = '0;
                  state_d   = ST_WLOAD;
               end
            end
            ST_WLOAD: begin
               if (w_acc) begin
                  wcnt_d = wcnt_q + 1'b1;
                  if (wcnt_q == CW'(N - 1))
                     state_d = (num_vec_q == 8'd0) ? ST_FLUSH : ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (a_acc) begin
                  vcnt_d = vcnt_q + 8'd1;
                  if (vcnt_q + 8'd1 == num_vec_q) state_d = ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               // Leave as soon as the final tagged result is being emitted.
               if (inflight_d == 8'd0) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= '0;
         vcnt_q      <= '0;
         num_vec_q   <= '0;
         inflight_q  <= '0;
         arr_wen_q   <= 1'b0;
         arr_pause_q <= 1'b0;
         arr_north_q <= '0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         vcnt_q      <= vcnt_d;
         num_vec_q   <= num_vec_d;
         inflight_q  <= inflight_d;
         arr_wen_q   <= w_acc;
         arr_pause_q <= pause_req;
         arr_north_q <= w_acc ? w_data : '0;
         if (run) tag_q <= {tag_q[TAG_LEN-2:0], a_acc};
      end
   end

   // West lane i lags lane 0 by i cycles; result column c is held N-1-c cycles to realign.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         skew_line #(.DEPTH(gi), .DW(DW)) u_west (
            .clk (clk),
            .rst (rst),
            .en  (run),
            .d   (a_acc ? a_data[gi*DW +: DW] : {DW{1'b0}}),
            .q   (arr_west[gi*DW +: DW])
         );
         skew_line #(.DEPTH(N - 1 - gi), .DW(DW)) u_deskew (
            .clk (clk),
            .rst (rst),
            .en  (run),
            .d   (arr_res[gi*DW +: DW]),
            .q   (res_deskew[gi*DW +: DW])
         );
      end
   endgenerate

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed jobs with random data, a behavioural array model
// on the array ports, and a vector-level reference for result timing and values.
module tb_systolic_seq_ctrl;
   import systolic_pkg::*;

   localparam int LAT = ARR_LAT + N - 1;
   localparam int H   = 64;
   localparam int VW  = N * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, pause_req = 1'b0, w_valid = 1'b0, a_valid = 1'b0;
   logic [7:0]    num_vec = '0;
   logic [VW-1:0] w_data = '0, a_data = '0, arr_res = '0;
   logic          busy, done, w_ready, a_ready, arr_wen, arr_pause, res_valid;
   logic [VW-1:0] arr_north, arr_west, res_data;

   int cyc = 0;
   int pass_cnt = 0, total_cnt = 0;
   int wen_cnt = 0, wen_in_pause = 0;

   logic [DW-1:0] w_arr [N][N];
   logic [DW-1:0] w_ref [N][N];
   logic [DW-1:0] west_hist [H][N];

   int            res_cyc_q[$];
   logic [VW-1:0] res_dat_q[$];
   int            done_cyc_q[$];
   int            exp_cyc_q[$];
   logic [VW-1:0] exp_dat_q[$];

   systolic_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_vec   (num_vec),
      .pause_req (pause_req),
      .busy      (busy),
      .done      (done),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_data    (a_data),
      .arr_wen   (arr_wen),
      .arr_pause (arr_pause),
      .arr_north (arr_north),
      .arr_west  (arr_west),
      .arr_res   (arr_res),
      .res_valid (res_valid),
      .res_data  (res_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Array model: column c result for the vector whose element 0 hit the west edge at
   // cycle s appears at s+ARR_LAT+c; element i of that vector reached row i at s+i.
   always @(posedge clk) begin
      #2;
      for (int c = 0; c < N; c++) begin
         int acc;
         acc = 0;
         for (int i = 0; i < N; i++) begin
            int t;
            t = cyc - ARR_LAT - c + i;
            if (t >= 0) acc += int'(west_hist[t % H][i]) * int'(w_arr[i][c]);
         end
         arr_res[c*DW +: DW] = acc[DW-1:0];
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) west_hist[cyc % H][i] = arr_west[i*DW +: DW];
      if (arr_wen) begin
         wen_cnt++;
         for (int r = N - 1; r > 0; r--)
            for (int c = 0; c < N; c++) w_arr[r][c] = w_arr[r-1][c];
         for (int c = 0; c < N; c++) w_arr[0][c] = arr_north[c*DW +: DW];
      end
      if (pause_req && arr_wen) wen_in_pause++;
      if (res_valid) begin
         res_cyc_q.push_back(cyc);
         res_dat_q.push_back(res_data);
      end
      if (done) done_cyc_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      res_cyc_q.delete(); res_dat_q.delete(); done_cyc_q.delete();
      exp_cyc_q.delete(); exp_dat_q.delete();
   endtask

   task automatic start_job(input logic [7:0] nv);
      wen_cnt = 0;
      start = 1'b1;
      num_vec = nv;
      tick();
      start = 1'b0;
      num_vec = 8'($urandom);
      @(negedge clk);
      chk("busy_after_start", busy, 1'b1);
      tick();
   endtask

   task automatic send_row(input int k, input logic [VW-1:0] row);
      logic got;
      int   n;
      got = 1'b0;
      n = 0;
      w_valid = 1'b1;
      w_data = row;
      while (!got && n < 50) begin
         @(negedge clk);
         got = w_ready;
         tick();
         n++;
      end
      w_valid = 1'b0;
      w_data = VW'($urandom);
      chk("row_accept", got, 1'b1);
      for (int c = 0; c < N; c++) w_ref[N-1-k][c] = row[c*DW +: DW];
   endtask

   task automatic load_rows(input logic all_ones);
      for (int k = 0; k < N; k++) send_row(k, all_ones ? {N{8'h01}} : VW'($urandom));
   endtask

   task automatic send_vec(input logic [VW-1:0] v);
      logic          got;
      int            n, ac;
      logic [VW-1:0] e;
      got = 1'b0;
      n = 0;
      ac = 0;
      a_valid = 1'b1;
      a_data = v;
      while (!got && n < 50) begin
         @(negedge clk);
         got = a_ready;
         ac = cyc;
         tick();
         n++;
      end
      a_valid = 1'b0;
      a_data = VW'($urandom);
      chk("vec_accept", got, 1'b1);
      for (int c = 0; c < N; c++) begin
         int acc;
         acc = 0;
         for (int i = 0; i < N; i++) acc += int'(v[i*DW +: DW]) * int'(w_ref[i][c]);
         e[c*DW +: DW] = acc[DW-1:0];
      end
      exp_cyc_q.push_back(ac + LAT);
      exp_dat_q.push_back(e);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 300 && done_cyc_q.size() == 0; k++) tick();
      repeat (15) tick();
   endtask

   task automatic check_job(input string tag);
      @(negedge clk);
      chk({tag, "_busy_idle"}, busy, 1'b0);
      tick();
      chk({tag, "_done_cnt"}, done_cyc_q.size(), 1);
      chk({tag, "_res_cnt"}, res_cyc_q.size(), exp_cyc_q.size());
      for (int i = 0; i < exp_cyc_q.size() && i < res_cyc_q.size(); i++) begin
         chk($sformatf("%s_res%0d_cycle", tag, i), res_cyc_q[i], exp_cyc_q[i]);
         chk($sformatf("%s_res%0d_data", tag, i), res_dat_q[i], exp_dat_q[i]);
      end
      if (res_cyc_q.size() > 0 && done_cyc_q.size() > 0)
         chk({tag, "_done_after_last"},
             (done_cyc_q[0] - res_cyc_q[res_cyc_q.size()-1]) inside {1, 2}, 1'b1);
      clear_q();
   endtask

   initial begin
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            w_arr[r][c] = '0;
            w_ref[r][c] = '0;
         end
      for (int t = 0; t < H; t++)
         for (int i = 0; i < N; i++) west_hist[t][i] = '0;

      // Reset state
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_w_ready", w_ready, 1'b0);
      chk("rst_a_ready", a_ready, 1'b0);
      chk("rst_arr_wen", arr_wen, 1'b0);
      chk("rst_arr_pause", arr_pause, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_arr_north", arr_north, '0);
      chk("rst_arr_west", arr_west, '0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      clear_q();

      // All-ones weights with a staircase of activations
      start_job(8'd4);
      load_rows(1'b1);
      send_vec(32'h0000_0001);
      send_vec(32'h0000_0101);
      send_vec(32'h0001_0101);
      send_vec(32'h0101_0101);
      wait_done();
      chk("t2_wen_cnt", wen_cnt, N);
      chk("t2_lanes_v0", res_dat_q.size() == 4 ? res_dat_q[0] : '0, 32'h0101_0101);
      chk("t2_lanes_v3", res_dat_q.size() == 4 ? res_dat_q[3] : '0, 32'h0404_0404);
      check_job("t2");

      // Reset in the middle of streaming
      start_job(8'd4);
      load_rows(1'b0);
      send_vec(VW'($urandom));
      @(negedge clk);
      chk("t1_in_stream", a_ready, 1'b1);
      tick();
      send_vec(VW'($urandom));
      a_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("t1_busy", busy, 1'b0);
      chk("t1_a_ready", a_ready, 1'b0);
      chk("t1_w_ready", w_ready, 1'b0);
      chk("t1_arr_wen", arr_wen, 1'b0);
      chk("t1_arr_west", arr_west, '0);
      chk("t1_res_valid", res_valid, 1'b0);
      chk("t1_res_data", res_data, '0);
      chk("t1_done", done, 1'b0);
      tick();
      a_valid = 1'b0;
      rst = 1'b0;
      clear_q();
      repeat (20) tick();
      chk("t1_no_res_after_abort", res_cyc_q.size(), 0);
      chk("t1_no_done_after_abort", done_cyc_q.size(), 0);
      clear_q();

      // a_valid gap of two cycles mid-stream
      start_job(8'd6);
      load_rows(1'b0);
      for (int v = 0; v < 3; v++) send_vec(VW'($urandom));
      tick();
      tick();
      for (int v = 0; v < 3; v++) send_vec(VW'($urandom));
      wait_done();
      chk("t3_gap", res_cyc_q.size() >= 4 ? res_cyc_q[3] - res_cyc_q[2] : -1, 3);
      check_job("t3");

      // Pause for 5 cycles during weight load after two rows
      start_job(8'd3);
      send_row(0, VW'($urandom));
      send_row(1, VW'($urandom));
      tick();
      pause_req = 1'b1;
      w_valid = 1'b1;
      for (int p = 0; p < 5; p++) begin
         @(negedge clk);
         chk($sformatf("t4_pause%0d_w_ready", p), w_ready, 1'b0);
         chk($sformatf("t4_pause%0d_arr_wen", p), arr_wen, 1'b0);
         tick();
      end
      @(negedge clk);
      chk("t4_arr_pause", arr_pause, 1'b1);
      tick();
      pause_req = 1'b0;
      send_row(2, VW'($urandom));
      send_row(3, VW'($urandom));
      for (int v = 0; v < 3; v++) send_vec(VW'($urandom));
      wait_done();
      chk("t4_wen_cnt", wen_cnt, N);
      chk("t4_wen_in_pause", wen_in_pause, 0);
      check_job("t4");

      // Empty job
      start_job(8'd0);
      load_rows(1'b0);
      wait_done();
      chk("t5_wen_cnt", wen_cnt, N);
      check_job("t5");

      // start pulsed while streaming is ignored
      start_job(8'd5);
      load_rows(1'b0);
      send_vec(VW'($urandom));
      send_vec(VW'($urandom));
      start = 1'b1;
      num_vec = 8'd2;
      tick();
      start = 1'b0;
      for (int v = 0; v < 3; v++) send_vec(VW'($urandom));
      wait_done();
      repeat (10) tick();
      check_job("t6");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
